fp_window_acc: RTL and testbench
================================

// Module: fp_window_acc
// PURPOSE
//  Sequential FP32 accumulator that sums one convolution window (TAPS products) into one result.
//  Sits directly downstream of the combinational fpaddsub_32b; the partial sum and the incoming term
//  feed it, and its output is registered. Per-window products arrive on a valid/ready stream and
//  each completed window sum is emitted on a valid/ready stream to the output-feature-map writer.
// PARAMETERS
//  M      8   exponent width
//  N      23  mantissa width (word = M+N+1 bits)
//  TAPS   9   terms per window (3x3 kernel); legal range 1..2**CNT_W-1
//  CNT_W  4   term-counter width
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  clr        in   1      synchronous abort: discard the current partial window
//  in_valid   in   1      in_data valid
//  in_ready   out  1      block accepts in_data this cycle
//  in_data    in   M+N+1  product term, IEEE-754 layout {sign,exp,mant}
//  out_valid  out  1      out_data holds a completed window sum
//  out_ready  in   1      consumer takes out_data this cycle
//  out_data   out  M+N+1  window sum
//  out_cnt    out  CNT_W  terms accepted in the current window (debug/monitor)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=S_FIRST, acc=0, cnt=0, out_valid=0, out_data=0, out_cnt=0.
//  Accept = in_valid & in_ready. in_ready = (state!=S_HOLD) & ~clr (combinational).
//  FSM:
//   S_FIRST: on accept acc<=in_data, cnt<=1; TAPS==1 -> S_HOLD (out_data<=in_data), else -> S_ACC.
//   S_ACC:   on accept acc<=f(acc,in_data), cnt<=cnt+1; when cnt==TAPS-1 -> S_HOLD,
//            out_data<=f(acc,in_data), out_valid<=1.
//   S_HOLD:  in_ready=0; out_data/out_valid stable; on out_ready -> S_FIRST, out_valid<=0, cnt<=0.
//  Latency: out_valid rises the cycle after the TAPS-th accept. No new term is accepted in the cycle
//   out_ready is taken (S_HOLD -> S_FIRST first); max throughput 1 window per TAPS+1 cycles.
//  f(a,b) (zero/cancellation guards; the adder has an implicit leading 1 and cannot handle them):
//   - b exponent==0 -> a (term treated as zero, still counted)
//   - a exponent==0 -> b
//   - a[M+N-1:0]==b[M+N-1:0] and a sign != b sign -> 32'h0000_0000 (+0)
//   - else adder output with sub=0.
//  No overflow/NaN/denormal handling; exponent wrap is the adder's behaviour, not flagged.
//  clr: takes priority over in_valid (term not accepted) in S_FIRST/S_ACC -> S_FIRST, cnt=0, acc=0.
//   clr in S_HOLD is ignored; the pending result is still delivered.
//  out_cnt = cnt, registered.
//  Reset mid-window or mid-hold: everything returns to reset values immediately; partial sum lost.
// STRUCTURE
//  Shared package fp_conv_pkg: FP_M/FP_N/FP_W constants, FP_ZERO constant, exp/sign field
//   slicing helpers, state enum {S_FIRST,S_ACC,S_HOLD}.
//  One sub-module: fpaddsub_32b instance (a=acc, b=in_data, sub=0); guard mux and FSM in this file.
// TESTING
//  1) 9 x 3F80_0000 (1.0), out_ready=1 -> one out_valid pulse, out_data=4110_0000 (9.0), 1 cycle after 9th accept.
//  2) 1.0, BF80_0000 (-1.0), then 7 x 1.0 -> 40E0_0000 (7.0); cancellation step gives acc=0000_0000.
//  3) 0000_0000, then 8 x 4000_0000 (2.0) -> 4180_0000 (16.0); out_cnt reaches 9 with the zero counted.
//  4) Window done, out_ready=0 for 5 cycles -> in_ready=0, out_data stable, in_valid ignored; release -> handshake once.
//  5) 4 x 1.0, clr with in_valid=1 -> term dropped, out_cnt=0; then 9 x 2.0 -> 4190_0000 (18.0).
//  6) rst_n low after 5 terms and during S_HOLD -> outputs reset asynchronously; next 9 x 1.0 -> 4110_0000.

Source files
------------

// File: rtl/fp_conv_pkg.sv
// Shared FP32 definitions for the convolution datapath: field widths, field helpers and FSM states.
package fp_conv_pkg;

  localparam int unsigned FP_M = 8;
  localparam int unsigned FP_N = 23;
  localparam int unsigned FP_W = FP_M + FP_N + 1;

  localparam logic [FP_W-1:0] FP_ZERO = '0;

  typedef struct packed {
    logic            sign;
    logic [FP_M-1:0] exp;
    logic [FP_N-1:0] mant;
  } fp32_t;

  typedef enum logic [1:0] {S_FIRST, S_ACC, S_HOLD} state_e;

  function automatic logic [FP_M-1:0] fp_exp(input logic [FP_W-1:0] x);
    return x[FP_W-2 -: FP_M];
  endfunction

  function automatic logic fp_sign(input logic [FP_W-1:0] x);
    return x[FP_W-1];
  endfunction

  function automatic logic [FP_W-2:0] fp_mag(input logic [FP_W-1:0] x);
    return x[FP_W-2:0];
  endfunction

endpackage

// File: rtl/fpaddsub_32b.sv
// Combinational FP32 add/subtract for normalised operands (implicit leading 1), round-to-nearest-even.
module fpaddsub_32b
  import fp_conv_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  input  logic            sub,
  output logic [FP_W-1:0] sum_c
);

  localparam int unsigned SW  = FP_N + 1;
  localparam int unsigned XW  = SW + 3;
  localparam int unsigned LZW = $clog2(XW);

  fp32_t               big, sml;
  logic                a_big;
  logic [FP_M-1:0]     diff;
  logic [2*SW+1:0]     sml_sh;
  logic [XW-1:0]       big_x, sml_x, norm;
  logic [XW:0]         raw;
  logic [FP_M+1:0]     e_n;
  logic [SW:0]         rnd;
  logic [FP_N-1:0]     mant;
  logic [LZW-1:0]      lz;
  logic                found;

  always_comb begin
    big    = '0;
    sml    = '0;
    norm   = '0;
    lz     = '0;
    found  = 1'b0;
    mant   = '0;
    sum_c  = FP_ZERO;

    // Order operands by magnitude so the difference path never goes negative.
    a_big = fp_mag(a) >= fp_mag(b);
    if (a_big) begin
      big = a;
      sml = {fp_sign(b) ^ sub, fp_mag(b)};
    end else begin
      big = {fp_sign(b) ^ sub, fp_mag(b)};
      sml = a;
    end

    diff   = big.exp - sml.exp;
    sml_sh = {1'b1, sml.mant, (SW+2)'(0)} >> diff;
    sml_x  = {sml_sh[2*SW+1:SW], |sml_sh[SW-1:0]};
    big_x  = {1'b1, big.mant, 3'b000};

    raw = (big.sign ^ sml.sign) ? ({1'b0, big_x} - {1'b0, sml_x})
                                : ({1'b0, big_x} + {1'b0, sml_x});
    e_n = {2'b00, big.exp};

    if (raw[XW]) begin
      norm = {raw[XW:2], raw[1] | raw[0]};
      e_n  = e_n + (FP_M+2)'(1);
    end else begin
      for (int i = XW - 1; i >= 0; i--) begin
        if (!found && raw[i]) begin
          found = 1'b1;
          lz    = LZW'(XW - 1 - i);
        end
      end
      norm = raw[XW-1:0] << lz;
      e_n  = e_n - (FP_M+2)'(lz);
    end

    // Guard/round/sticky live in norm[2:0]; ties round to even.
    rnd = {1'b0, norm[XW-1:3]} + (SW+1)'(norm[2] & (norm[1] | norm[0] | norm[3]));
    if (rnd[SW]) begin
      e_n  = e_n + (FP_M+2)'(1);
      mant = rnd[SW-1:1];
    end else begin
      mant = rnd[SW-2:0];
    end

    if (raw != '0) begin
      sum_c = {big.sign, e_n[FP_M-1:0], mant};
    end
  end

endmodule

// File: rtl/fp_window_acc.sv
// Sequential FP32 window accumulator: sums TAPS stream terms into one registered result with handshake.
module fp_window_acc
  import fp_conv_pkg::*;
#(
  parameter int unsigned TAPS  = 9,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FP_W-1:0]  out_data,
  output logic [CNT_W-1:0] out_cnt
);

  state_e           state_q, state_d;
  logic [FP_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [FP_W-1:0]  out_data_q, out_data_d;
  logic [FP_W-1:0]  add_c, f_c;
  logic             accept;

  fpaddsub_32b u_add (
    .a     (acc_q),
    .b     (in_data),
    .sub   (1'b0),
    .sum_c (add_c)
  );

  // Zero and exact-cancellation cases bypass the adder, which assumes a leading 1.
  always_comb begin
    f_c = add_c;
    if (fp_exp(in_data) == '0) begin
      f_c = acc_q;
    end else if (fp_exp(acc_q) == '0) begin
      f_c = in_data;
    end else if ((fp_mag(acc_q) == fp_mag(in_data)) && (fp_sign(acc_q) != fp_sign(in_data))) begin
      f_c = FP_ZERO;
    end
  end

  assign in_ready = (state_q != S_HOLD) && !clr;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      S_FIRST: begin
        if (clr) begin
          acc_d = FP_ZERO;
          cnt_d = '0;
        end else if (accept) begin
          acc_d = in_data;
          cnt_d = CNT_W'(1);
          if (TAPS == 32'd1) begin
            state_d     = S_HOLD;
            out_data_d  = in_data;
            out_valid_d = 1'b1;
          end else begin
            state_d = S_ACC;
          end
        end
      end
      S_ACC: begin
        if (clr) begin
          state_d = S_FIRST;
          acc_d   = FP_ZERO;
          cnt_d   = '0;
        end else if (accept) begin
          acc_d = f_c;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(TAPS - 1)) begin
            state_d     = S_HOLD;
            out_data_d  = f_c;
            out_valid_d = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d     = S_FIRST;
          out_valid_d = 1'b0;
          cnt_d       = '0;
        end
      end
      default: state_d = S_FIRST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FIRST;
      acc_q       <= FP_ZERO;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= FP_ZERO;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_cnt   = cnt_q;

endmodule

// File: tb/tb_fp_window_acc.sv
// Bench for fp_window_acc: directed window table, hand-written handshake/clear/reset sequences, random integer windows.
module tb_fp_window_acc;

  localparam int unsigned TAPS = 9;

  logic        clk = 1'b0;
  logic        rst_n, clr, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [3:0]  out_cnt;

  int nvec = 0;
  int nerr = 0;

  fp_window_acc #(.TAPS(TAPS), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] t [TAPS];
    logic [31:0] sum;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Exact FP32 encoding of a small integer (|v| < 2**24).
  function automatic logic [31:0] int2fp(input int v);
    int          mag, msb;
    logic [31:0] r;
    if (v == 0) return 32'h0000_0000;
    mag = (v < 0) ? -v : v;
    msb = 0;
    for (int i = 0; i < 31; i++) if ((mag >> i) != 0) msb = i;
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + msb);
    r[22:0]  = 23'(mag << (23 - msb));
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    #1;
    while (!in_ready && n < 40) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (!in_ready) begin
      nvec++;
      nerr++;
      $display("FAIL push_timeout: got in_ready %b expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int sum, v, gap;

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #3;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", out_data, 32'h0);
    chk("reset_out_cnt", 32'(out_cnt), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    tbl[0].name = "nine_ones";   tbl[0].t = '{9{32'h3F80_0000}}; tbl[0].sum = 32'h4110_0000;
    tbl[1].name = "cancel";      tbl[1].t = '{32'h3F80_0000, 32'hBF80_0000, 32'h3F80_0000, 32'h3F80_0000,
                                              32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000,
                                              32'h3F80_0000};           tbl[1].sum = 32'h40E0_0000;
    tbl[2].name = "zero_first";  tbl[2].t = '{32'h0000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000,
                                              32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000,
                                              32'h4000_0000};           tbl[2].sum = 32'h4180_0000;
    tbl[3].name = "one_point_5"; tbl[3].t = '{9{32'h3FC0_0000}}; tbl[3].sum = 32'h4158_0000;
    tbl[4].name = "three_minus"; tbl[4].t = '{32'h4040_0000, 32'hBF80_0000, 32'hBF80_0000, 32'hBF80_0000,
                                              32'hBF80_0000, 32'hBF80_0000, 32'hBF80_0000, 32'hBF80_0000,
                                              32'hBF80_0000};           tbl[4].sum = 32'hC0A0_0000;

    for (int w = 0; w < 5; w++) begin
      for (int k = 0; k < TAPS; k++) begin
        push(tbl[w].t[k]);
        if (k == TAPS - 2) chk({tbl[w].name, "_early_valid"}, 32'(out_valid), 32'd0);
      end
      chk({tbl[w].name, "_valid"}, 32'(out_valid), 32'd1);
      chk({tbl[w].name, "_data"}, out_data, tbl[w].sum);
      chk({tbl[w].name, "_cnt"}, 32'(out_cnt), 32'(TAPS));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tbl[w].name, "_drop"}, 32'(out_valid), 32'd0);
      chk({tbl[w].name, "_cnt_clr"}, 32'(out_cnt), 32'd0);
    end

    // Consumer stalls: hold is stable, inputs and clr ignored, single handshake on release.
    for (int k = 0; k < TAPS; k++) push(32'h3F80_0000);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_data = 32'h4000_0000; clr = (c == 2);
      #1;
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", out_data, 32'h4110_0000);
      tick();
    end
    in_valid = 1'b0; clr = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hold_release", 32'(out_valid), 32'd0);
    tick();
    chk("hold_once", 32'(out_valid), 32'd0);
    chk("hold_no_term", 32'(out_cnt), 32'd0);

    // Abort mid-window: term offered with clr is dropped.
    for (int k = 0; k < 4; k++) push(32'h3F80_0000);
    chk("clr_pre_cnt", 32'(out_cnt), 32'd4);
    clr = 1'b1; in_valid = 1'b1; in_data = 32'h3F80_0000;
    #1;
    chk("clr_in_ready", 32'(in_ready), 32'd0);
    tick();
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_cnt", 32'(out_cnt), 32'd0);
    for (int k = 0; k < TAPS; k++) push(32'h4000_0000);
    chk("clr_after_data", out_data, 32'h4190_0000);
    chk("clr_after_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Asynchronous reset mid-window and mid-hold.
    for (int k = 0; k < 5; k++) push(32'h3F80_0000);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_cnt", 32'(out_cnt), 32'd0);
    @(negedge clk); rst_n = 1'b1; tick();
    for (int k = 0; k < TAPS; k++) push(32'h3F80_0000);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_hold_valid", 32'(out_valid), 32'd0);
    chk("rst_hold_data", out_data, 32'h0);
    @(negedge clk); rst_n = 1'b1; tick();
    for (int k = 0; k < TAPS; k++) push(32'h3F80_0000);
    chk("rst_after_data", out_data, 32'h4110_0000);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Random integer-valued windows against an exact integer sum.
    for (int w = 0; w < 30; w++) begin
      if ($urandom_range(0, 4) == 0) begin
        for (int k = 0; k < 3; k++) push(int2fp(7));
        clr = 1'b1; tick(); clr = 1'b0;
      end
      sum = 0;
      for (int k = 0; k < TAPS; k++) begin
        gap = int'($urandom_range(0, 2));
        for (int g = 0; g < gap; g++) tick();
        v = ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(0, 128)) - 64;
        sum += v;
        push(int2fp(v));
      end
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) tick();
      chk("rand_valid", 32'(out_valid), 32'd1);
      chk("rand_data", out_data, int2fp(sum));
      out_ready = 1'b1; tick(); out_ready = 1'b0;
    end

    do_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
